// File: rtl/imem_loader.sv
// Boot loader: turns a LEN-prefixed little-endian byte stream into instruction-memory writes, then releases the core.
// Latency: one registered mem_we per 4 accepted bytes; in_ready drops in RUN/ERR, so later bytes are stalled, not consumed.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_resetn,
   output logic              done,
   output logic              error
);

   // Length field is 16 bits, so the memory cannot be addressed beyond that.
   localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state;
   logic [15:0]       len;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] word_idx;
   logic [23:0]       asm_word;

   logic              xfer;
   logic [15:0]       len_full;
   logic              last_word;

   assign xfer      = in_valid && in_ready;
   assign len_full  = {in_data, len[7:0]};
   assign last_word = (16'(word_idx) == (len - 16'd1));
   assign done      = core_resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_LEN_LO;
         in_ready    <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         core_resetn <= 1'b0;
         error       <= 1'b0;
         len         <= '0;
         byte_idx    <= '0;
         word_idx    <= '0;
         asm_word    <= '0;
      end else begin
         mem_we      <= 1'b0;
         core_resetn <= (state == S_RUN);
         case (state)
            S_LEN_LO: begin
               in_ready <= 1'b1;
               if (xfer) begin
                  len[7:0] <= in_data;
                  state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= in_data;
                  byte_idx  <= '0;
                  word_idx  <= '0;
                  if (len_full == 16'd0) begin
                     state    <= S_RUN;
                     in_ready <= 1'b0;
                  end else if ({1'b0, len_full} > DEPTH) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_word[7:0]   <= in_data;
                     2'd1: asm_word[15:8]  <= in_data;
                     2'd2: asm_word[23:16] <= in_data;
                     default: begin
                        // Fourth byte goes straight into the write data; no need to store it.
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx;
                        mem_wdata <= {in_data, asm_word};
                        word_idx  <= word_idx + 1'b1;
                        if (last_word) begin
                           state    <= S_RUN;
                           in_ready <= 1'b0;
                        end
                     end
                  endcase
               end
            end
            S_RUN: begin
               in_ready <= 1'b0;
            end
            default: begin
               in_ready <= 1'b0;
               error    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-005 in_data  input  8  byte-stream payload.
REQ-006 in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
REQ-007 mem_we  output  1  one-cycle write strobe to instruction memory write port.
REQ-008 mem_addr  output  ADDR_W  word address for mem_we.
REQ-009 mem_wdata  output  32  instruction word for mem_we.
REQ-010 core_resetn  output  1  active-low reset to the processor core; high only once the program is fully loaded.
REQ-011 done  output  1  load complete; equals core_resetn.
REQ-012 error  output  1  sticky: requested length exceeds DEPTH.

Function
REQ-013 Stream format: 16-bit word count LEN (low byte first), then LEN instruction words, each 4 bytes little-endian (byte 0 = bits 7:0).
REQ-014 States: LEN_LO, LEN_HI, DATA, RUN, ERR; reset state LEN_LO.
REQ-015 in_ready is 1 in LEN_LO, LEN_HI, DATA; 0 in RUN and ERR (bytes presented then are ignored, not consumed).
REQ-016 LEN_LO: on transfer, capture LEN[7:0] -> LEN_HI; no transfer -> stay.
REQ-017 LEN_HI: on transfer, capture LEN[15:8]; full LEN==0 -> RUN; LEN>DEPTH -> ERR; else -> DATA with byte index 0, word index 0.
REQ-018 DATA: each transfer places in_data into byte lane [byte index] of an assembly register and increments the 2-bit byte index (wraps 3->0).
REQ-019 On the 4th byte transfer, mem_we=1 in the next cycle only, with mem_addr = word index and mem_wdata = assembled word; word index then increments.
REQ-020 Gaps in in_valid are legal at any point; no timeout; partial word held indefinitely.
REQ-021 Transfer of the last byte of word LEN-1 moves state to RUN on the same edge that registers the final mem_we.
REQ-022 core_resetn is registered = (state==RUN); rises exactly one cycle after the final mem_we cycle (one cycle after entering RUN for LEN==0).
REQ-023 LEN==DEPTH is legal; final word index DEPTH-1, no address wrap; no writes issued beyond LEN words.
REQ-024 ERR: no mem_we ever issued, error=1, core_resetn=0, in_ready=0; exit only via resetn.
REQ-025 RUN is terminal until resetn; mem_we=0 in RUN except the final-word strobe cycle.
REQ-026 Back-to-back bytes (in_valid held high) sustain one byte per cycle; one word written every 4 cycles.

Reset
REQ-027 resetn low asynchronously forces: state LEN_LO, in_ready=0 while asserted, mem_we=0, mem_addr=0, mem_wdata=0, core_resetn=0, done=0, error=0, byte/word indices 0, LEN=0.
REQ-028 in_ready becomes 1 on the first clock edge after resetn deasserts.
REQ-029 Reset mid-load discards the partial word and LEN; already-written memory contents are not cleared; a fresh stream must restart with LEN.

Verification
REQ-030 Swap program: stream 06 00, then 93 80 90 01, 13 01 b1 04, b3 80 20 00, 33 81 20 40, b3 80 20 40, 93 80 d0 ff -> mem_we at addr 0..5 with 0x01908093, 0x04b10113, 0x002080b3, 0x40208133, 0x402080b3, 0xffd08093; core_resetn=1 one cycle after addr 5 write.
REQ-031 Same program with in_valid randomly deasserted 0-3 cycles between bytes -> identical write sequence; no extra or duplicate mem_we.
REQ-032 Stream 00 00 -> no mem_we; core_resetn rises two cycles after the LEN_HI byte; subsequent bytes see in_ready=0.
REQ-033 ADDR_W=8, stream 01 01 (LEN=257) -> error=1, in_ready=0, core_resetn stays 0, no mem_we; LEN=256 (00 01) with 1024 bytes -> last write addr 0xFF, done=1.
REQ-034 LEN=2, send 4 bytes + 2 bytes, assert resetn low mid-word -> outputs to reset values immediately; restart with LEN=1 and AA BB CC DD -> single write addr 0 data 0xDDCCBBAA.
